// File: rtl/tap_pkg.sv
// Shared types and constants for the TAP front end: state encoding, opcodes,
// register lengths and the next-state / decode helpers used by tap_fsm.
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PAU_DR = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PAU_IR = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_dec_t;

  localparam int unsigned IR_LEN        = 4;
  localparam int unsigned DR_LEN_BYPASS = 1;
  localparam int unsigned DR_LEN_IDCODE = 32;
  localparam int unsigned DR_LEN_BSR    = 10;
  localparam int unsigned DR_LEN_STATUS = 16;

  localparam logic [IR_LEN-1:0] OP_BYPASS     = 4'hF;
  localparam logic [IR_LEN-1:0] OP_IDCODE     = 4'h1;
  localparam logic [IR_LEN-1:0] OP_GETTEST    = 4'h8;
  localparam logic [IR_LEN-1:0] OP_RUNBIST    = 4'h9;
  localparam logic [IR_LEN-1:0] OP_READSTATUS = 4'hA;

  localparam logic [IR_LEN-1:0]        IR_RESET   = 4'h1;
  localparam logic [IR_LEN-1:0]        IR_CAPTURE = 4'b0101;
  localparam logic [DR_LEN_IDCODE-1:0] IDCODE_VAL = 32'h1000_563B;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: return tms ? TAP_SEL_DR : TAP_RTI;
      default:    return TAP_TLR;
    endcase
  endfunction

  function automatic tap_dec_t tap_decode(input tap_state_e s);
    tap_dec_t d;
    d.tlr        = (s == TAP_TLR);
    d.capture_dr = (s == TAP_CAP_DR);
    d.shift_dr   = (s == TAP_SH_DR);
    d.update_dr  = (s == TAP_UPD_DR);
    d.capture_ir = (s == TAP_CAP_IR);
    d.shift_ir   = (s == TAP_SH_IR);
    d.update_ir  = (s == TAP_UPD_IR);
    return d;
  endfunction

  // Unknown opcodes fall back to the 1-bit BYPASS path.
  function automatic logic [IR_LEN-1:0] select_op(input logic [IR_LEN-1:0] ir);
    case (ir)
      OP_IDCODE, OP_GETTEST, OP_RUNBIST, OP_READSTATUS: return ir;
      default: return OP_BYPASS;
    endcase
  endfunction

  function automatic logic [DR_LEN_IDCODE-1:0] dr_shift(
    input logic [DR_LEN_IDCODE-1:0] v,
    input logic                     b,
    input logic [4:0]               msb
  );
    logic [DR_LEN_IDCODE-1:0] r;
    r      = v >> 1;
    r[msb] = b;
    return r;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// JTAG pins plus the Bist-block side signals of the TAP front end.
interface tap_controller_if;
  import tap_pkg::*;

  logic                     tms;
  logic                     tdi;
  logic                     tdo;
  logic                     tdo_en;
  logic                     tlr;
  logic                     capturedr;
  logic                     updatedr;
  logic                     runbist_select;
  logic                     gettest_select;
  logic [DR_LEN_BSR-1:0]    bsr;
  logic [DR_LEN_STATUS-1:0] bist_status;

  modport master (
    output tms, tdi, bist_status,
    input  tdo, tdo_en, tlr, capturedr, updatedr, runbist_select, gettest_select, bsr
  );

  modport slave (
    input  tms, tdi, bist_status,
    output tdo, tdo_en, tlr, capturedr, updatedr, runbist_select, gettest_select, bsr
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP controller; state decodes are registered from the next state
// so they line up exactly with the cycles spent in each state.
//   TLR test-logic-reset | RTI run-test/idle | SEL_* select scan column
//   CAP_* capture        | SH_* shift        | EX1_*/EX2_* exit1/exit2
//   PAU_* pause (hold)   | UPD_* update      | *_DR data column, *_IR instruction column
module tap_fsm
  import tap_pkg::*;
(
  input  logic     tck,
  input  logic     trst_n,
  input  logic     tms_i,
  output tap_dec_t dec_o,
  output logic     goto_tlr_o
);

  tap_state_e state_q, state_d;
  tap_dec_t   dec_q;

  assign state_d    = tap_next(state_q, tms_i);
  assign goto_tlr_o = (state_d == TAP_TLR);
  assign dec_o      = dec_q;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= TAP_TLR;
      dec_q   <= tap_decode(TAP_TLR);
    end else begin
      state_q <= state_d;
      dec_q   <= tap_decode(state_d);
    end
  end

endmodule

// File: rtl/tap_controller.sv
// TAP front end top: IR, data-register shifters, TDO mux and the negedge
// output flop, driving the Bist block through the slave modport.
module tap_controller
  import tap_pkg::*;
(
  input logic             tck,
  input logic             trst_n,
  tap_controller_if.slave jtag
);

  tap_dec_t dec;
  logic     goto_tlr;

  logic [IR_LEN-1:0]        ir_q, ir_d;
  logic [IR_LEN-1:0]        ir_sr_q, ir_sr_d;
  logic [IR_LEN-1:0]        op;
  logic [DR_LEN_IDCODE-1:0] dr_q, dr_d;
  logic [DR_LEN_BSR-1:0]    bsr_q, bsr_d;
  logic                     tdo_q, tdo_en_q, tdo_mux, shifting;

  tap_fsm u_fsm (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms_i      (jtag.tms),
    .dec_o      (dec),
    .goto_tlr_o (goto_tlr)
  );

  assign op       = select_op(ir_q);
  assign shifting = dec.shift_dr | dec.shift_ir;

  // IR resets on the edge that enters TLR, not one cycle after.
  always_comb begin
    ir_sr_d = ir_sr_q;
    if (dec.capture_ir) begin
      ir_sr_d = IR_CAPTURE;
    end else if (dec.shift_ir) begin
      ir_sr_d = {jtag.tdi, ir_sr_q[IR_LEN-1:1]};
    end
    ir_d = ir_q;
    if (goto_tlr) begin
      ir_d = IR_RESET;
    end else if (dec.update_ir) begin
      ir_d = ir_sr_q;
    end
  end

  always_comb begin
    dr_d  = dr_q;
    bsr_d = bsr_q;
    if (dec.capture_dr) begin
      case (op)
        OP_IDCODE:     dr_d = IDCODE_VAL;
        OP_READSTATUS: begin
          dr_d                    = '0;
          dr_d[DR_LEN_STATUS-1:0] = jtag.bist_status;
        end
        OP_GETTEST:    dr_d = dr_q;
        default:       dr_d = '0;
      endcase
    end else if (dec.shift_dr) begin
      case (op)
        OP_IDCODE:     dr_d = dr_shift(dr_q, jtag.tdi, 5'(DR_LEN_IDCODE - 1));
        OP_READSTATUS: dr_d = dr_shift(dr_q, jtag.tdi, 5'(DR_LEN_STATUS - 1));
        OP_GETTEST:    bsr_d = {jtag.tdi, bsr_q[DR_LEN_BSR-1:1]};
        default:       dr_d = dr_shift(dr_q, jtag.tdi, 5'(DR_LEN_BYPASS - 1));
      endcase
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q    <= IR_RESET;
      ir_sr_q <= '0;
      dr_q    <= '0;
      bsr_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      dr_q    <= dr_d;
      bsr_q   <= bsr_d;
    end
  end

  always_comb begin
    tdo_mux = dr_q[0];
    if (dec.shift_ir) begin
      tdo_mux = ir_sr_q[0];
    end else if (op == OP_GETTEST) begin
      tdo_mux = bsr_q[0];
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= shifting ? tdo_mux : 1'b0;
      tdo_en_q <= shifting;
    end
  end

  assign jtag.tdo            = tdo_q;
  assign jtag.tdo_en         = tdo_en_q;
  assign jtag.tlr            = dec.tlr;
  assign jtag.capturedr      = dec.capture_dr;
  assign jtag.updatedr       = dec.update_dr;
  assign jtag.runbist_select = (ir_q == OP_RUNBIST);
  assign jtag.gettest_select = (ir_q == OP_GETTEST);
  assign jtag.bsr            = bsr_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: expected TDO bits are queued as
// stimulus is planned and popped as each bit is observed.
module tb_tap_controller;

  logic tck    = 1'b0;
  logic trst_n = 1'b0;

  tap_controller_if jtag ();

  tap_controller dut (
    .tck    (tck),
    .trst_n (trst_n),
    .jtag   (jtag)
  );

  always #10 tck = ~tck;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  // Inputs change just after negedge; everything is sampled at negedge+2.
  task automatic step(input logic t, input logic d);
    jtag.tms = t;
    jtag.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  task automatic load_ir(input logic [3:0] opc, output logic [3:0] cap,
                         output logic rb_upd, output logic gt_upd);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = jtag.tdo;
      step(i == 3, opc[i]);
    end
    step(1'b1, 1'b0);
    rb_upd = jtag.runbist_select;
    gt_upd = jtag.gettest_select;
    step(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, input int pause_at,
                          output logic [31:0] dout, output int en_bad, output int cap_cnt,
                          output int upd_cnt, output logic [9:0] bsr_upd);
    dout    = '0;
    en_bad  = 0;
    cap_cnt = 0;
    upd_cnt = 0;
    bsr_upd = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    if (jtag.capturedr) cap_cnt++;
    step(1'b0, 1'b0);
    if (jtag.capturedr) cap_cnt++;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag.tdo;
      if (jtag.tdo_en !== 1'b1) en_bad++;
      step((i == n - 1) || (i == pause_at - 1), din[i]);
      if (jtag.updatedr) upd_cnt++;
      if ((i == pause_at - 1) && (i != n - 1)) begin
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (jtag.capturedr) cap_cnt++;
      end
    end
    step(1'b1, 1'b0);
    if (jtag.updatedr) upd_cnt++;
    bsr_upd = jtag.bsr;
    step(1'b0, 1'b0);
    if (jtag.updatedr) upd_cnt++;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    logic [16:0] rst_vec = {1'b1, 6'b0, 10'h000};
    logic [3:0]  cap;
    logic        rb, gt;
    logic [31:0] dout;
    int          eb, cc, uc;
    logic [9:0]  bu;
    got = {jtag.tlr, jtag.capturedr, jtag.updatedr, jtag.runbist_select,
           jtag.gettest_select, jtag.tdo, jtag.tdo_en, jtag.bsr};
    checks++;
    if (got !== rst_vec) begin
      failures++;
      $display("FAIL reset_initial: got %h expected %h", got, rst_vec);
    end
    step(1'b0, 1'b0);
    load_ir(4'h8, cap, rb, gt);
    shift_dr(10, 32'h3FF, 0, dout, eb, cc, uc, bu);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if ({jtag.tdo_en, jtag.gettest_select} !== 2'b11) begin
      failures++;
      $display("FAIL mid_shift_state: tdo_en/gettest got %b expected 11",
               {jtag.tdo_en, jtag.gettest_select});
    end
    trst_n = 1'b0;
    #3;
    got = {jtag.tlr, jtag.capturedr, jtag.updatedr, jtag.runbist_select,
           jtag.gettest_select, jtag.tdo, jtag.tdo_en, jtag.bsr};
    checks++;
    if (got !== rst_vec) begin
      failures++;
      $display("FAIL reset_mid_shift: got %h expected %h", got, rst_vec);
    end
    #2;
    trst_n = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if ({jtag.tlr, jtag.updatedr} !== 2'b10) begin
      failures++;
      $display("FAIL release_tms1: tlr/updatedr got %b expected 10", {jtag.tlr, jtag.updatedr});
    end
    step(1'b0, 1'b0);
    checks++;
    if (jtag.tlr !== 1'b0) begin
      failures++;
      $display("FAIL release_tms0_rti: tlr got %b expected 0", jtag.tlr);
    end
  endtask

  task automatic test_gettest();
    logic [3:0]  cap;
    logic        rb, gt;
    logic [31:0] dout;
    int          eb, cc, uc;
    logic [9:0]  bu;
    logic [9:0]  pat = 10'h2A5;
    load_ir(4'h8, cap, rb, gt);
    checks++;
    if ({jtag.gettest_select, jtag.runbist_select} !== 2'b10) begin
      failures++;
      $display("FAIL gettest_select: got %b expected 10", {jtag.gettest_select, jtag.runbist_select});
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) exp_q.push_back(pass == 0 ? 1'b0 : pat[i]);
      shift_dr(10, {22'h0, pat}, 0, dout, eb, cc, uc, bu);
      for (int i = 0; i < 10; i++) begin
        logic e;
        e = exp_q.pop_front();
        checks++;
        if (dout[i] !== e) begin
          failures++;
          $display("FAIL bsr_tdo pass %0d bit %0d: got %b expected %b", pass, i, dout[i], e);
        end
      end
      checks++;
      if (uc !== 1 || bu !== pat || jtag.bsr !== pat) begin
        failures++;
        $display("FAIL bsr_update pass %0d: updatedr_cycles %0d bsr_at_update %h bsr_after %h expected 1 %h %h",
                 pass, uc, bu, jtag.bsr, pat, pat);
      end
    end
  endtask

  task automatic test_runbist_select();
    logic [3:0] cap;
    logic       rb, gt;
    load_ir(4'h9, cap, rb, gt);
    checks++;
    if (cap !== 4'b0101) begin
      failures++;
      $display("FAIL ir_capture: first tdo bits (lsb first) got %b expected 0101", cap);
    end
    checks++;
    if ({rb, gt} !== 2'b01) begin
      failures++;
      $display("FAIL select_in_update_ir: runbist/gettest got %b expected 01", {rb, gt});
    end
    checks++;
    if ({jtag.runbist_select, jtag.gettest_select} !== 2'b10) begin
      failures++;
      $display("FAIL runbist_select: got %b expected 10", {jtag.runbist_select, jtag.gettest_select});
    end
  endtask

  task automatic test_tlr_idcode();
    logic [31:0] idc = 32'h1000_563B;
    logic [31:0] din;
    logic [31:0] dout;
    int          eb, cc, uc;
    logic [9:0]  bu;
    repeat (5) step(1'b1, 1'b0);
    checks++;
    if ({jtag.tlr, jtag.runbist_select, jtag.gettest_select} !== 3'b100 || jtag.bsr !== 10'h2A5) begin
      failures++;
      $display("FAIL tms_tlr: tlr/rb/gt got %b bsr %h expected 100 bsr 2a5",
               {jtag.tlr, jtag.runbist_select, jtag.gettest_select}, jtag.bsr);
    end
    step(1'b0, 1'b0);
    din = $urandom;
    for (int i = 0; i < 32; i++) exp_q.push_back(idc[i]);
    shift_dr(32, din, 0, dout, eb, cc, uc, bu);
    for (int i = 0; i < 32; i++) begin
      logic e;
      e = exp_q.pop_front();
      checks++;
      if (dout[i] !== e) begin
        failures++;
        $display("FAIL idcode_tdo bit %0d: got %b expected %b", i, dout[i], e);
      end
    end
    checks++;
    if (eb !== 0) begin
      failures++;
      $display("FAIL idcode_tdo_en: low during shift %0d times expected 0", eb);
    end
  endtask

  task automatic test_readstatus();
    logic [3:0]  cap;
    logic        rb, gt;
    logic [31:0] dout;
    int          eb, cc, uc;
    logic [9:0]  bu;
    logic [15:0] st;
    load_ir(4'hA, cap, rb, gt);
    for (int run = 0; run < 2; run++) begin
      st = (run == 0) ? 16'hABCF : 16'h5A3C;
      jtag.bist_status = st;
      for (int i = 0; i < 16; i++) exp_q.push_back(st[i]);
      shift_dr(16, 32'h0, (run == 0) ? 0 : 7, dout, eb, cc, uc, bu);
      jtag.bist_status = 16'h0;
      for (int i = 0; i < 16; i++) begin
        logic e;
        e = exp_q.pop_front();
        checks++;
        if (dout[i] !== e) begin
          failures++;
          $display("FAIL status_tdo run %0d bit %0d: got %b expected %b", run, i, dout[i], e);
        end
      end
      checks++;
      if (cc !== 1 || eb !== 0) begin
        failures++;
        $display("FAIL status_capture run %0d: capturedr_cycles %0d tdo_en_low %0d expected 1 0",
                 run, cc, eb);
      end
    end
  endtask

  task automatic test_bypass();
    logic [3:0]  cap;
    logic        rb, gt;
    logic [31:0] dout;
    int          eb, cc, uc;
    logic [9:0]  bu;
    logic [7:0]  pat = 8'b1011_0010;
    logic [3:0]  ops [2] = '{4'hF, 4'h3};
    for (int k = 0; k < 2; k++) begin
      load_ir(ops[k], cap, rb, gt);
      exp_q.push_back(1'b0);
      for (int i = 1; i < 8; i++) exp_q.push_back(pat[i-1]);
      shift_dr(8, {24'h0, pat}, 0, dout, eb, cc, uc, bu);
      for (int i = 0; i < 8; i++) begin
        logic e;
        e = exp_q.pop_front();
        checks++;
        if (dout[i] !== e) begin
          failures++;
          $display("FAIL bypass_tdo op %h bit %0d: got %b expected %b", ops[k], i, dout[i], e);
        end
      end
      checks++;
      if ({jtag.runbist_select, jtag.gettest_select} !== 2'b00) begin
        failures++;
        $display("FAIL bypass_selects op %h: got %b expected 00", ops[k],
                 {jtag.runbist_select, jtag.gettest_select});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    jtag.tms         = 1'b1;
    jtag.tdi         = 1'b0;
    jtag.bist_status = 16'h0;
    repeat (2) @(negedge tck);
    #2;
    trst_n = 1'b1;
    test_reset();
    test_gettest();
    test_runbist_select();
    test_tlr_idcode();
    test_readstatus();
    test_bypass();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1-style TAP front end for the JTAG/BIST subsystem. It runs the 16-state TAP FSM on TCK and holds the 4-bit instruction register and the data registers (BYPASS, IDCODE, 10-bit BSR load, 16-bit status). It drives the TLR, UPDATEDR, CAPTUREDR, RUNBIST_SELECT, GETTEST_SELECT and BSR inputs of the downstream Bist block, and captures its BIST_STATUS for readout on TDO.

## Interface
- IDCODE, 32'h1000_563B, value captured by IDCODE instruction (bit 0 must be 1)
- IR_RESET, 4'h1, opcode loaded into IR in Test-Logic-Reset

- TCK  in  1  TAP clock; all state on posedge, except TDO on negedge
- TRST  in  1  asynchronous, active-low reset
- TMS  in  1  mode select, sampled posedge TCK
- TDI  in  1  serial data in, sampled posedge TCK
- TDO  out  1  serial data out, negedge TCK
- TDO_EN  out  1  high while in Shift-IR/Shift-DR (negedge-registered)
- TLR  out  1  state == Test-Logic-Reset
- CAPTUREDR  out  1  state == Capture-DR
- UPDATEDR  out  1  state == Update-DR
- RUNBIST_SELECT  out  1  IR == RUNBIST
- GETTEST_SELECT  out  1  IR == GETTEST
- BSR  out  10  GETTEST shift register contents; [9:5] config, [4:0] check
- BIST_STATUS  in  16  status word, captured in Capture-DR under READSTATUS

## Operation
- FSM: standard 16 states. TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR and Update-DR, plus the IR mirror states. Transitions are on TMS per 1149.1.
- Five consecutive TMS=1 reach TLR from any state.
- Opcodes:
  - BYPASS 4'hF
  - IDCODE 4'h1
  - GETTEST 4'h8
  - RUNBIST 4'h9
  - READSTATUS 4'hA
  - Any undefined opcode selects BYPASS.
- IR path:
  - Capture-IR loads the shift stage with 4'b0101.
  - Shift-IR shifts TDI into bit 3, and bit 0 goes to TDO.
  - Update-IR copies the shift stage into IR on the posedge that leaves Update-IR.
  - In TLR, IR = IR_RESET.
- DR path, per IR; all shift LSB first out, TDI into MSB:
  - BYPASS: 1 bit, captures 0.
  - RUNBIST: 1 bit, captures 0.
  - IDCODE: 32 bits, captures IDCODE.
  - GETTEST: 10-bit BSR shifter, no capture (holds contents).
  - READSTATUS: 16 bits, captures BIST_STATUS.
- BSR shifts only in Shift-DR with GETTEST selected. It is held stable through Exit1/Pause/Exit2/Update-DR so the consumer samples it with UPDATEDR.
- Select outputs are decoded from the registered IR. They change only on Update-IR or on entry to TLR.
- Strobe outputs (TLR, CAPTUREDR, UPDATEDR) are Moore decodes of the registered state. Each is high for exactly the TCK cycles spent in that state.

## Timing
- Reset (TRST=0, asynchronous):
  - state = TLR, IR = IR_RESET, all shifters 0
  - TDO = 0, TDO_EN = 0
  - TLR = 1, CAPTUREDR = 0, UPDATEDR = 0
  - RUNBIST_SELECT = 0, GETTEST_SELECT = 0, BSR = 10'h000
- TRST release: the FSM leaves TLR only on a posedge with TMS=0.
- TDO and TDO_EN update on the negedge following the posedge shift. First bit out is shifter bit 0 after Capture.
- UPDATEDR is a single TCK cycle per Update-DR visit. A consumer on TCK sees it on exactly one posedge, with BSR unchanged that cycle.
- Entering TLR via TMS has the same effect as TRST except it is synchronous: IR resets on that posedge. BSR contents are retained.
- TRST asserted mid-Shift: immediate return to reset values. No partial Update is generated.
- Pause-DR/Pause-IR hold shifters indefinitely. Exit2 → Shift resumes without recapture.

## Structure
- Package tap_pkg:
  - 4-bit state encoding enum
  - opcode localparams
  - IR capture constant 4'b0101
  - DR length constants: 1, 32, 10, 16
- Sub-module tap_fsm: TCK, TRST, TMS → state, plus one-hot decodes (capture/shift/update for DR and IR, tlr).
- The top level holds IR, the DR shifters, the TDO mux and the negedge output flop.

## Test plan
- TRST low mid-Shift-DR, then release → all outputs at reset values and TLR=1. A TMS=0 posedge → RTI and TLR=0.
- From RTI, TMS=1×5 → TLR asserted, IR reads IDCODE. Shift 32 DR bits → TDO stream equals 32'h1000_563B, LSB first.
- Load IR=4'h8, shift 10 bits of 10'h2A5 in Shift-DR, go to Update-DR → BSR=10'h2A5 and GETTEST_SELECT=1. UPDATEDR is high for exactly one posedge and BSR is stable during it.
- Drive BIST_STATUS=16'hABCF, IR=4'hA, Capture then Shift 16 → TDO yields 16'hABCF. CAPTUREDR pulses one cycle.
- IR=4'hF (and undefined 4'h3), shift 8'b1011_0010 → TDO reproduces the pattern delayed by one bit after a leading 0.
- Shift-IR capture check: first 4 TDO bits after Capture-IR are 1,0,1,0. IR=4'h9 → RUNBIST_SELECT=1 after Update-IR, not before.
